// File: rtl/hit_window_counter_pkg.sv
// Shared definitions for the hit window counter.
// Holds the FSM state encoding and a width-parameterised saturating increment.
package hit_window_counter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Adds inc to val and clamps the result at 2^width-1. Widths up to 32 are
  // supported; callers cast the 32-bit result back to their own width.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic        inc,
                                          input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    if (inc && (val < max_val)) begin
      return val + 32'd1;
    end
    return val;
  endfunction

endpackage

// File: rtl/hit_window_counter_window_timer.sv
// Window position timer.
// Ports: clk, rst (sync, active-high), clr (return to window start),
//        step (advance one cycle), last_cycle (index is at WIN_LEN-1).
module window_timer #(
  parameter int unsigned WIN_LEN = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic step,
  output logic last_cycle
);

  localparam int unsigned IDX_W = $clog2(WIN_LEN);

  logic [IDX_W-1:0] win_idx;

  assign last_cycle = (win_idx == IDX_W'(WIN_LEN - 1));

  // Wrap explicitly so non-power-of-two window lengths close on time.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      win_idx <= '0;
    end else if (step) begin
      win_idx <= last_cycle ? '0 : win_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/hit_window_counter.sv
// Counts detector hits over fixed windows of WIN_LEN clocks and publishes each
// window total through a valid/ready output register.
// Ports: clk, rst (sync, active-high), en (run / abort window), hit (match flag),
//        clr_ovr (clear sticky overrun), count_out/out_valid/out_ready (report
//        handshake), overrun (report dropped while pending), busy (state is RUN).
module hit_window_counter
  import hit_window_counter_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned WIN_LEN = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             hit,
  input  logic             clr_ovr,
  output logic [CNT_W-1:0] count_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             busy
);

  state_t           state;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] acc_inc;
  logic             counting;
  logic             aborting;
  logic             last_cycle;
  logic             close;

  assign counting = (state == RUN) && en;
  assign aborting = (state == RUN) && !en;
  assign close    = counting && last_cycle;
  assign acc_inc  = CNT_W'(sat_inc(32'(acc), hit, CNT_W));
  assign busy     = (state == RUN);

  window_timer #(
    .WIN_LEN(WIN_LEN)
  ) u_window_timer (
    .clk       (clk),
    .rst       (rst),
    .clr       (aborting),
    .step      (counting),
    .last_cycle(last_cycle)
  );

  // FSM, accumulator and report register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      count_out <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) state <= RUN;
        end
        RUN: begin
          if (!en) begin
            state <= IDLE;
            acc   <= '0;
          end else if (last_cycle) begin
            acc <= '0;
          end else begin
            acc <= acc_inc;
          end
        end
        default: state <= IDLE;
      endcase

      // A close with a simultaneous accept reloads and keeps out_valid high.
      if (close && (!out_valid || out_ready)) begin
        count_out <= acc_inc;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      // A new overrun event takes priority over a clear in the same cycle.
      if (close && out_valid && !out_ready) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hit_window_counter.sv
// Table-driven bench for hit_window_counter. Three instances share one set of
// inputs; each vector names the instance whose outputs it checks.
//   sel 0: CNT_W=8, WIN_LEN=4   sel 1: CNT_W=2, WIN_LEN=8   sel 2: CNT_W=8, WIN_LEN=8
module tb_hit_window_counter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic hit = 1'b0;
  logic clr_ovr = 1'b0;
  logic out_ready = 1'b0;

  logic [7:0] count_a;
  logic [1:0] count_s;
  logic [7:0] count_b;
  logic       valid_a, valid_s, valid_b;
  logic       ovr_a, ovr_s, ovr_b;
  logic       busy_a, busy_s, busy_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hit_window_counter #(.CNT_W(8), .WIN_LEN(4)) u_a (
    .clk(clk), .rst(rst), .en(en), .hit(hit), .clr_ovr(clr_ovr),
    .count_out(count_a), .out_valid(valid_a), .out_ready(out_ready),
    .overrun(ovr_a), .busy(busy_a)
  );

  hit_window_counter #(.CNT_W(2), .WIN_LEN(8)) u_s (
    .clk(clk), .rst(rst), .en(en), .hit(hit), .clr_ovr(clr_ovr),
    .count_out(count_s), .out_valid(valid_s), .out_ready(out_ready),
    .overrun(ovr_s), .busy(busy_s)
  );

  hit_window_counter #(.CNT_W(8), .WIN_LEN(8)) u_b (
    .clk(clk), .rst(rst), .en(en), .hit(hit), .clr_ovr(clr_ovr),
    .count_out(count_b), .out_valid(valid_b), .out_ready(out_ready),
    .overrun(ovr_b), .busy(busy_b)
  );

  typedef struct {
    int         sel;
    logic       rst, en, hit, rdy, clr;
    logic       valid;
    logic [7:0] count;
    logic       ovr, busy;
  } vec_t;

  vec_t vq[$];

  task automatic v(input int sel, input logic r, input logic e, input logic h,
                   input logic rd, input logic c, input logic ev,
                   input logic [7:0] ec, input logic eo, input logic eb);
    vec_t t;
    t.sel = sel; t.rst = r; t.en = e; t.hit = h; t.rdy = rd; t.clr = c;
    t.valid = ev; t.count = ec; t.ovr = eo; t.busy = eb;
    vq.push_back(t);
  endtask

  task automatic check_outs(input string name, input int sel, input logic ev,
                            input logic [7:0] ec, input logic eo, input logic eb);
    logic       av, ao, ab;
    logic [7:0] ac;
    case (sel)
      1:       begin av = valid_s; ac = 8'(count_s); ao = ovr_s; ab = busy_s; end
      2:       begin av = valid_b; ac = count_b;     ao = ovr_b; ab = busy_b; end
      default: begin av = valid_a; ac = count_a;     ao = ovr_a; ab = busy_a; end
    endcase
    n_tests++;
    if (av !== ev || ac !== ec || ao !== eo || ab !== eb) begin
      n_fail++;
      $display("FAIL %s: got valid=%b count=%0d overrun=%b busy=%b, want valid=%b count=%0d overrun=%b busy=%b",
               name, av, ac, ao, ab, ev, ec, eo, eb);
    end
  endtask

  initial begin
    // Density: WIN_LEN=4, all hits, ready tied high.
    v(0, 1,0,0,0,0, 0,0,0,0);
    v(0, 0,1,1,1,0, 0,0,0,1);
    for (int i = 0; i < 3; i++) v(0, 0,1,1,1,0, 0,0,0,1);
    v(0, 0,1,1,1,0, 1,4,0,1);
    for (int i = 0; i < 3; i++) v(0, 0,1,1,1,0, 0,4,0,1);
    v(0, 0,1,1,1,0, 1,4,0,1);

    // Back-to-back: pattern 1,0,1,1 with ready only in close cycles.
    v(0, 1,0,0,0,0, 0,0,0,0);
    v(0, 0,1,0,0,0, 0,0,0,1);
    v(0, 0,1,1,0,0, 0,0,0,1);
    v(0, 0,1,0,0,0, 0,0,0,1);
    v(0, 0,1,1,0,0, 0,0,0,1);
    v(0, 0,1,1,1,0, 1,3,0,1);
    v(0, 0,1,1,0,0, 1,3,0,1);
    v(0, 0,1,0,0,0, 1,3,0,1);
    v(0, 0,1,1,0,0, 1,3,0,1);
    v(0, 0,1,1,1,0, 1,3,0,1);
    for (int i = 0; i < 3; i++) v(0, 0,1,1,0,0, 1,3,0,1);
    v(0, 0,1,1,1,0, 1,4,0,1);

    // Overrun, recovery, and set-beats-clear.
    v(0, 1,0,0,0,0, 0,0,0,0);
    v(0, 0,1,0,0,0, 0,0,0,1);
    v(0, 0,1,1,0,0, 0,0,0,1);
    v(0, 0,1,0,0,0, 0,0,0,1);
    v(0, 0,1,0,0,0, 0,0,0,1);
    v(0, 0,1,0,0,0, 1,1,0,1);
    v(0, 0,1,1,0,0, 1,1,0,1);
    v(0, 0,1,1,0,0, 1,1,0,1);
    v(0, 0,1,0,0,0, 1,1,0,1);
    v(0, 0,1,0,0,0, 1,1,1,1);
    v(0, 0,1,0,1,0, 0,1,1,1);
    v(0, 0,1,0,0,1, 0,1,0,1);
    v(0, 0,1,0,0,0, 0,1,0,1);
    v(0, 0,1,0,0,0, 1,0,0,1);
    for (int i = 0; i < 3; i++) v(0, 0,1,0,0,0, 1,0,0,1);
    v(0, 0,1,0,0,1, 1,0,1,1);

    // Sync reset with a pending report, overrun set and a partial window.
    v(0, 0,1,1,0,0, 1,0,1,1);
    v(0, 1,1,1,0,0, 0,0,0,0);
    v(0, 0,1,1,0,0, 0,0,0,1);

    // Saturation: CNT_W=2, WIN_LEN=8, all hits.
    v(1, 1,0,0,0,0, 0,0,0,0);
    v(1, 0,1,1,0,0, 0,0,0,1);
    for (int i = 0; i < 7; i++) v(1, 0,1,1,0,0, 0,0,0,1);
    v(1, 0,1,1,0,0, 1,3,0,1);

    // Abort: WIN_LEN=8, five hits then en drops; next window of zeros reports 0.
    v(2, 1,0,0,0,0, 0,0,0,0);
    v(2, 0,1,0,0,0, 0,0,0,1);
    for (int i = 0; i < 5; i++) v(2, 0,1,1,0,0, 0,0,0,1);
    v(2, 0,0,1,0,0, 0,0,0,0);
    v(2, 0,0,0,0,0, 0,0,0,0);
    v(2, 0,1,0,0,0, 0,0,0,1);
    for (int i = 0; i < 7; i++) v(2, 0,1,0,0,0, 0,0,0,1);
    v(2, 0,1,0,0,0, 1,0,0,1);

    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].rst; en = vq[i].en; hit = vq[i].hit;
      out_ready = vq[i].rdy; clr_ovr = vq[i].clr;
      @(posedge clk);
      #1;
      check_outs($sformatf("vec%0d", i), vq[i].sel, vq[i].valid, vq[i].count,
                 vq[i].ovr, vq[i].busy);
    end

    // Reset raised between edges must wait for the next rising edge.
    @(negedge clk);
    rst = 1'b1; en = 1'b0; hit = 1'b0; out_ready = 1'b0; clr_ovr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; en = 1'b1;
    @(posedge clk);
    #1;
    check_outs("run_before_midcycle_rst", 0, 1'b0, 8'd0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_outs("midcycle_rst_no_effect", 0, 1'b0, 8'd0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check_outs("midcycle_rst_at_edge", 0, 1'b0, 8'd0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
